// File: rtl/regfile_pkg.sv
// Shared defaults and register-index type for the register file with scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 3;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback or flush.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
)(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic              issue_ready,
  output logic [DEPTH-1:0]  pending
);

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_next;
  logic             w_issue_fire;

  // A writeback to the same destination frees the slot this cycle, so a re-issue is allowed.
  assign issue_ready  = !flush &&
                        ((issue_dest == '0) || !r_pending[issue_dest] ||
                         (wb_valid && (wb_addr == issue_dest)));
  assign w_issue_fire = issue_valid && issue_ready && (issue_dest != '0);

  always_comb begin
    w_pending_next = r_pending;
    if (flush) begin
      w_pending_next = '0;
    end else begin
      if (wb_valid) w_pending_next[wb_addr] = 1'b0;
      // Set after clear: a same-edge issue keeps the register pending.
      if (w_issue_fire) w_pending_next[issue_dest] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pending <= '0;
    else          r_pending <= w_pending_next;
  end

  assign pending = r_pending;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with pending-write scoreboard; r0 is hardwired zero.
// Optional same-cycle writeback forwarding to read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
)(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dest,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_pending;

  // Async clear of the whole array rules out block RAM; these are plain flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (wb_valid && (wb_addr != '0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .flush       (flush),
    .issue_ready (issue_ready),
    .pending     (w_pending)
  );

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      logic w_hit;
      assign w_hit = wb_valid && (wb_addr == w_addr) && (w_addr != '0);
      assign rd_data[gi*DATA_W +: DATA_W] = w_hit ? wb_data : r_regs[w_addr];
      assign rd_busy[gi]                  = w_hit ? 1'b0 : w_pending[w_addr];
`else
      assign rd_data[gi*DATA_W +: DATA_W] = r_regs[w_addr];
      assign rd_busy[gi]                  = w_pending[w_addr];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: behavioural model compared every cycle plus literal checks.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] rd_addr = '0;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic        issue_valid = 1'b0;
  reg_idx_t    issue_dest = '0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  reg_idx_t    wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;

  logic [19:0]  w2_rd_addr = '0;
  logic [255:0] w2_rd_data;
  logic [3:0]   w2_rd_busy;
  logic         w2_issue_valid = 1'b0;
  reg_idx_t     w2_issue_dest = '0;
  logic         w2_issue_ready;
  logic         w2_wb_valid = 1'b0;
  reg_idx_t     w2_wb_addr = '0;
  logic [63:0]  w2_wb_data = '0;
  logic         w2_flush = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  regfile_scoreboard u_dut (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush)
  );

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4)) u_wide (
    .clock(clock), .reset_n(reset_n), .rd_addr(w2_rd_addr), .rd_data(w2_rd_data),
    .rd_busy(w2_rd_busy), .issue_valid(w2_issue_valid), .issue_dest(w2_issue_dest),
    .issue_ready(w2_issue_ready), .wb_valid(w2_wb_valid), .wb_addr(w2_wb_addr),
    .wb_data(w2_wb_data), .flush(w2_flush)
  );

  // Architectural model: register contents and outstanding-write set.
  logic [31:0] m_mem  [32];
  logic        m_pend [32];

  function automatic bit m_ready();
    return !flush && ((issue_dest == 0) || !m_pend[issue_dest] ||
                      (wb_valid && wb_addr == issue_dest));
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
    end else begin
      if (wb_valid && wb_addr != 0) m_mem[wb_addr] <= wb_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
      end else begin
        if (wb_valid) m_pend[wb_addr] <= 1'b0;
        if (issue_valid && m_ready() && issue_dest != 0) m_pend[issue_dest] <= 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    $display("txn %s: got 0x%0h expected 0x%0h", nm, act, exp);
    check(nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      for (int k = 0; k < 3; k++) begin
        logic [4:0]  a;
        logic        hit;
        logic [31:0] ed;
        logic        eb;
        a   = rd_addr[k*5 +: 5];
        hit = BYP && wb_valid && (wb_addr == a) && (a != 0);
        ed  = hit ? wb_data : m_mem[a];
        eb  = hit ? 1'b0 : m_pend[a];
        check($sformatf("model_port%0d_data", k), 64'(rd_data[k*32 +: 32]), 64'(ed));
        check($sformatf("model_port%0d_busy", k), 64'(rd_busy[k]), 64'(eb));
      end
      check("model_issue_ready", 64'(issue_ready), 64'(m_ready()));
    end
  end

  function automatic logic [31:0] rdd(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  function automatic logic [63:0] wrd(input int k);
    return w2_rd_data[k*64 +: 64];
  endfunction

  task automatic to_edge();
    @(posedge clock); #1;
  endtask

  task automatic at_mid();
    @(negedge clock); #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_addr = {5'd5, 5'd5, 5'd5};
    issue_dest = 5'd5;
    to_edge(); to_edge();
    lit("rst_data0", 64'(rdd(0)), 64'h0);
    lit("rst_busy", 64'(rd_busy), 64'h0);
    lit("rst_ready", 64'(issue_ready), 64'h1);
    to_edge();
    reset_n = 1'b1;
    at_mid();
    lit("post_rst_data2", 64'(rdd(2)), 64'h0);
    lit("post_rst_ready", 64'(issue_ready), 64'h1);

    // Issue r7, check busy and WAW stall, then write back.
    to_edge(); issue_valid = 1'b1; issue_dest = 5'd7;
    at_mid(); lit("issue_r7_ready", 64'(issue_ready), 64'h1);
    to_edge(); rd_addr = {5'd5, 5'd5, 5'd7};
    at_mid();
    lit("r7_busy", 64'(rd_busy[0]), 64'h1);
    lit("r7_waw_ready", 64'(issue_ready), 64'h0);
    to_edge(); issue_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    at_mid();
    lit("r7_wb_cycle_data", 64'(rdd(0)), BYP ? 64'hDEADBEEF : 64'h0);
    lit("r7_wb_cycle_busy", 64'(rd_busy[0]), BYP ? 64'h0 : 64'h1);
    to_edge(); idle();
    at_mid();
    lit("r7_data", 64'(rdd(0)), 64'hDEADBEEF);
    lit("r7_busy_clear", 64'(rd_busy[0]), 64'h0);

    // Same-cycle write and read of r3.
    to_edge(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h12345678;
    rd_addr = {5'd5, 5'd3, 5'd7};
    at_mid(); lit("r3_same_cycle", 64'(rdd(1)), BYP ? 64'h12345678 : 64'h0);
    to_edge(); idle();
    at_mid(); lit("r3_next_cycle", 64'(rdd(1)), 64'h12345678);

    // r9 pending; re-issue with same-cycle writeback.
    to_edge(); issue_valid = 1'b1; issue_dest = 5'd9; rd_addr = {5'd9, 5'd3, 5'd7};
    to_edge(); wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
    at_mid();
    lit("r9_reissue_ready", 64'(issue_ready), 64'h1);
    lit("r9_wb_cycle_busy", 64'(rd_busy[2]), BYP ? 64'h0 : 64'h1);
    to_edge(); idle();
    at_mid();
    lit("r9_data", 64'(rdd(2)), 64'hA5A5A5A5);
    lit("r9_still_pending", 64'(rd_busy[2]), 64'h1);
    to_edge(); wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1;
    to_edge(); idle();

    // r0 is immune to writes and issues.
    to_edge(); wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_dest = 5'd0; rd_addr = {5'd5, 5'd5, 5'd0};
    at_mid();
    lit("r0_issue_ready", 64'(issue_ready), 64'h1);
    lit("r0_wb_cycle_data", 64'(rdd(0)), 64'h0);
    to_edge(); idle();
    at_mid();
    lit("r0_data", 64'(rdd(0)), 64'h0);
    lit("r0_busy", 64'(rd_busy[0]), 64'h0);

    // Pend r4, r6, then flush with a discarded issue and a live writeback.
    to_edge(); issue_valid = 1'b1; issue_dest = 5'd4;
    to_edge(); issue_dest = 5'd6;
    to_edge(); flush = 1'b1; issue_dest = 5'd5; wb_valid = 1'b1; wb_addr = 5'd4;
    wb_data = 32'h44; rd_addr = {5'd5, 5'd6, 5'd4};
    at_mid();
    lit("flush_ready", 64'(issue_ready), 64'h0);
    lit("pre_flush_r6_busy", 64'(rd_busy[1]), 64'h1);
    to_edge(); idle();
    at_mid();
    lit("post_flush_busy", 64'(rd_busy), 64'h0);
    lit("flush_wb_r4", 64'(rdd(0)), 64'h44);

    // Wide instance: four ports.
    to_edge(); w2_wb_valid = 1'b1; w2_wb_addr = 5'd1; w2_wb_data = 64'h1;
    to_edge(); w2_wb_addr = 5'd2; w2_wb_data = 64'h2;
    to_edge(); w2_wb_valid = 1'b0; w2_rd_addr = {5'd0, 5'd1, 5'd2, 5'd1};
    at_mid();
    lit("wide_p0", wrd(0), 64'h1);
    lit("wide_p1", wrd(1), 64'h2);
    lit("wide_p2", wrd(2), 64'h1);
    lit("wide_p3", wrd(3), 64'h0);

    // Mixed directed table, checked by the model each cycle.
    for (int i = 0; i < 16; i++) begin
      to_edge();
      issue_valid = (i % 3) != 0;
      issue_dest  = 5'((i * 5) % 32);
      wb_valid    = (i % 2) == 1;
      wb_addr     = 5'((i * 7) % 32);
      wb_data     = 32'(i) * 32'h11111111;
      flush       = (i == 9);
      rd_addr     = {5'((i * 7) % 32), 5'((i * 5) % 32), 5'((i * 3) % 32)};
    end
    to_edge(); idle();

    // Reset mid-operation clears contents asynchronously.
    to_edge(); rd_addr = {5'd9, 5'd3, 5'd7}; reset_n = 1'b0;
    #1;
    lit("midrst_data0", 64'(rdd(0)), 64'h0);
    lit("midrst_data1", 64'(rdd(1)), 64'h0);
    lit("midrst_busy", 64'(rd_busy), 64'h0);
    to_edge(); reset_n = 1'b1;
    at_mid();
    lit("after_midrst_r3", 64'(rdd(1)), 64'h0);

    to_edge();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
